// File: rtl/division_restoring_core.sv
// Restoring divider: one quotient bit per clock, sign fix-up on exit.
// Takes operand magnitudes plus original signs and returns signed results.
module division_restoring_core #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         div_sel,
  input  logic [W-1:0] mag_a,
  input  logic [W-1:0] mag_b,
  input  logic         sign_a,
  input  logic         sign_b,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_busy,
  output logic         div_finish,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    SIGN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  r_q;
  logic [W-1:0]  q_q;
  logic [W-1:0]  b_q;
  logic          sa_q;
  logic          sb_q;
  logic          dbz_q;
  logic [CW-1:0] cnt;

  logic [W:0]    r_sh;
  logic [W:0]    r_sub;
  logic [W-1:0]  q_fix;
  logic [W-1:0]  r_src;
  logic [W-1:0]  r_fix;

  assign r_sh  = {r_q, q_q[W-1]};
  assign r_sub = r_sh - {1'b0, b_q};

  // On divide-by-zero Q still holds the dividend, so it feeds the remainder.
  assign r_src = dbz_q ? q_q : r_q;
  assign r_fix = sa_q ? -r_src : r_src;
  assign q_fix = dbz_q ? {W{1'b1}} :
                 ((sa_q ^ sb_q) ? -q_q : q_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      b_q         <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      dbz_q       <= 1'b0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_busy    <= 1'b0;
      div_finish  <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (div_sel) begin
            q_q      <= mag_a;
            b_q      <= mag_b;
            sa_q     <= sign_a;
            sb_q     <= sign_b;
            r_q      <= '0;
            cnt      <= '0;
            div_busy <= 1'b1;
            dbz_q    <= (mag_b == '0);
            state    <= (mag_b == '0) ? SIGN : ITER;
          end
        end
        ITER: begin
          // A non-negative trial difference means the divisor fits.
          r_q <= r_sub[W] ? r_sh[W-1:0] : r_sub[W-1:0];
          q_q <= {q_q[W-2:0], ~r_sub[W]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1))
            state <= SIGN;
        end
        SIGN: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= dbz_q;
          div_finish  <= 1'b1;
          div_busy    <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          div_finish <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
